tone_synth: RTL

Parametrised tone generator for the buzzer path. It accepts a one-hot key vector from the key scanner, computes each note's oscillation period from a frequency table at elaboration time, and applies an octave shift. It drives a glitch-free square wave with selectable duty, plus a release tail after the key is let go. It replaces the fixed 16-key period lookup and feeds the buzzer pin directly.

---
 rtl/tone_pkg.sv | 18 +
 rtl/tone_period_lut.sv | 50 +++++
 rtl/tone_synth.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared constants and types for the buzzer tone generator.
// The scale table is in centihertz so that integer division gives usable periods.
package tone_pkg;

  localparam int NOTES_PER_OCT = 7;
  localparam int FREQ_CHZ [NOTES_PER_OCT] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RELEASE = 2'd2
  } tone_state_e;

  function automatic longint base_period(input longint clk_hz, input int deg);
    return (clk_hz * 100) / longint'(FREQ_CHZ[deg]);
  endfunction

endpackage

// File: rtl/tone_period_lut.sv
// Combinational key decode: lowest pressed key -> period, high time and key index.
// All division happens at elaboration; runtime logic is an encoder, a mux and shifts.
module tone_period_lut
  import tone_pkg::*;
#(
  parameter int CLK_HZ   = 12_000_000,
  parameter int NUM_KEYS = 16,
  parameter int CYC_W    = 16,
  parameter int IDX_W    = 4
) (
  input  logic [NUM_KEYS-1:0] key_i,
  input  logic [1:0]          oct_up_i,
  input  logic [1:0]          duty_sel_i,
  output logic                pressed_o,
  output logic [CYC_W-1:0]    target_o,
  output logic [CYC_W-1:0]    high_o,
  output logic [IDX_W-1:0]    idx_o
);

  localparam int SH_W = 6;

  if (base_period(CLK_HZ, 0) >= (longint'(1) << CYC_W)) begin : g_range_chk
    $error("tone_period_lut: lowest note period does not fit in CYC_W bits");
  end

  logic [CYC_W-1:0] key_base [NUM_KEYS];
  logic [SH_W-1:0]  key_oct  [NUM_KEYS];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    localparam longint BASE_K = base_period(CLK_HZ, k % NOTES_PER_OCT);
    assign key_base[k] = CYC_W'(BASE_K);
    assign key_oct[k]  = SH_W'(k / NOTES_PER_OCT);
  end

  logic [CYC_W-1:0] shifted;
  logic [CYC_W-1:0] high_raw;

  always_comb begin
    idx_o = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (key_i[IDX_W'(k)]) idx_o = IDX_W'(k);
    end
    pressed_o = |key_i;
    shifted   = key_base[idx_o] >> (key_oct[idx_o] + SH_W'(oct_up_i));
    target_o  = (shifted < CYC_W'(2)) ? CYC_W'(2) : shifted;
    high_raw  = target_o >> (3'd1 + 3'(duty_sel_i));
    high_o    = (high_raw == '0) ? CYC_W'(1) : high_raw;
  end

endmodule

// File: rtl/tone_synth.sv
// Buzzer tone generator: registered key inputs, IDLE/PLAY/RELEASE FSM, period counter.
// Period, duty and note are only reloaded at period boundaries so the wave never runts.
module tone_synth
  import tone_pkg::*;
#(
  parameter int CLK_HZ       = 12_000_000,
  parameter int NUM_KEYS     = 16,
  parameter int CYC_W        = 16,
  parameter int TAIL_PERIODS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_in,
  input  logic [1:0]                  oct_up,
  input  logic [1:0]                  duty_sel,
  output logic                        beep,
  output logic [CYC_W-1:0]            cycle,
  output logic [$clog2(NUM_KEYS)-1:0] note_idx,
  output logic                        active
);

  localparam int IDX_W  = $clog2(NUM_KEYS);
  localparam int TAIL_W = (TAIL_PERIODS > 1) ? $clog2(TAIL_PERIODS + 1) : 1;
  localparam logic [TAIL_W-1:0] TAIL_INIT = TAIL_W'(TAIL_PERIODS);
  localparam logic [TAIL_W-1:0] TAIL_M1   = TAIL_W'((TAIL_PERIODS > 0) ? TAIL_PERIODS - 1 : 0);

  logic [NUM_KEYS-1:0] key_q;
  logic [1:0]          oct_q, duty_q;
  tone_state_e         state_q, state_d;
  logic [CYC_W-1:0]    cnt_q, cnt_d, cycle_q, cycle_d, high_q, high_d;
  logic [IDX_W-1:0]    note_q, note_d;
  logic [TAIL_W-1:0]   tail_q, tail_d;
  logic                beep_q, beep_d;

  logic                pressed;
  logic [CYC_W-1:0]    lut_target, lut_high;
  logic [IDX_W-1:0]    lut_idx;
  logic                at_bnd;

  tone_period_lut #(
    .CLK_HZ  (CLK_HZ),
    .NUM_KEYS(NUM_KEYS),
    .CYC_W   (CYC_W),
    .IDX_W   (IDX_W)
  ) u_lut (
    .key_i     (key_q),
    .oct_up_i  (oct_q),
    .duty_sel_i(duty_q),
    .pressed_o (pressed),
    .target_o  (lut_target),
    .high_o    (lut_high),
    .idx_o     (lut_idx)
  );

  assign at_bnd = (cnt_q == cycle_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // With no tail configured, a released key keeps PLAY until the boundary, then goes straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pressed) state_d = PLAY;
      PLAY: begin
        if (!pressed) begin
          if (TAIL_PERIODS == 0) begin
            if (at_bnd) state_d = IDLE;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (at_bnd) begin
          if (pressed)            state_d = PLAY;
          else if (tail_q == '0)  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = at_bnd ? '0 : cnt_q + 1'b1;
    cycle_d = cycle_q;
    high_d  = high_q;
    note_d  = note_q;
    tail_d  = tail_q;
    if (state_d == IDLE) begin
      cnt_d   = '0;
      cycle_d = '0;
      high_d  = '0;
      note_d  = '0;
      tail_d  = '0;
    end else if ((state_q == IDLE) || (at_bnd && pressed)) begin
      cnt_d   = '0;
      cycle_d = lut_target;
      high_d  = lut_high;
      note_d  = lut_idx;
    end else if ((state_q == PLAY) && (state_d == RELEASE)) begin
      tail_d  = at_bnd ? TAIL_M1 : TAIL_INIT;
    end else if ((state_q == RELEASE) && at_bnd) begin
      tail_d  = tail_q - 1'b1;
    end
    beep_d = (state_d != IDLE) && (cnt_d < high_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      oct_q   <= '0;
      duty_q  <= '0;
      cnt_q   <= '0;
      cycle_q <= '0;
      high_q  <= '0;
      note_q  <= '0;
      tail_q  <= '0;
      beep_q  <= 1'b0;
    end else begin
      key_q   <= key_in;
      oct_q   <= oct_up;
      duty_q  <= duty_sel;
      cnt_q   <= cnt_d;
      cycle_q <= cycle_d;
      high_q  <= high_d;
      note_q  <= note_d;
      tail_q  <= tail_d;
      beep_q  <= beep_d;
    end
  end

  assign beep     = beep_q;
  assign cycle    = cycle_q;
  assign note_idx = note_q;
  assign active   = (state_q != IDLE);

endmodule
